// File: rtl/multi_pulse_counter.sv
// Multi-channel pulse edge counter with input synchronisers,
// per-channel clear, saturate/wrap, snapshot bank and muxed readout.
module multi_pulse_counter #(
  parameter int CH_NUM      = 4,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter bit SAT_EN      = 1'b1,
  localparam int SEL_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [CH_NUM-1:0]       i_pulse,
  input  logic                    i_en,
  input  logic [CH_NUM-1:0]       i_clr,
  input  logic [1:0]              i_edge_sel,
  input  logic                    i_snap,
  input  logic                    i_rd_en,
  input  logic [SEL_W-1:0]        i_rd_sel,
  output logic [CH_NUM*CNT_W-1:0] o_cnt,
  output logic [CH_NUM-1:0]       o_ovf,
  output logic [CNT_W-1:0]        o_rd_data,
  output logic                    o_rd_valid
);

  localparam int MASK_N = SYNC_STAGES + 1;
  localparam int MASK_W = $clog2(MASK_N + 1);

  logic [MASK_W-1:0] mask_cnt;
  logic              armed;
  logic              count_ok;

  logic [CH_NUM-1:0] lvl;
  logic [CH_NUM-1:0] hist;
  logic [CH_NUM-1:0] rise;
  logic [CH_NUM-1:0] fall;
  logic [CH_NUM-1:0] hit;

  logic [CNT_W-1:0] snap_arr [CH_NUM];
  logic [CNT_W-1:0] rd_mux;

  // Lines already high at reset release must not produce a count.
  assign armed = (mask_cnt == MASK_W'(MASK_N));
  assign count_ok = i_en & armed;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mask_cnt <= '0;
    end else if (!armed) begin
      mask_cnt <= mask_cnt + 1'b1;
    end
  end

  assign rise = lvl & ~hist;
  assign fall = ~lvl & hist;

  always_comb begin
    hit = '0;
    unique case (i_edge_sel)
      2'b00: hit = rise;
      2'b01: hit = fall;
      2'b10: hit = rise | fall;
      2'b11: hit = '0;
    endcase
  end

  for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       snap_q;
    logic                   ovf_q;

    assign lvl[n]  = sync_q[SYNC_STAGES-1];
    assign hist[n] = hist_q;

    // History tracks even while disabled so enabling never fakes an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        sync_q <= '0;
        hist_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], i_pulse[n]};
        hist_q <= sync_q[SYNC_STAGES-1];
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (i_clr[n]) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (hit[n] && count_ok) begin
        if (&cnt_q) begin
          ovf_q <= 1'b1;
          if (!SAT_EN) begin
            cnt_q <= '0;
          end
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        snap_q <= '0;
      end else if (i_snap) begin
        snap_q <= cnt_q;
      end
    end

    assign snap_arr[n]               = snap_q;
    assign o_cnt[n*CNT_W +: CNT_W]   = cnt_q;
    assign o_ovf[n]                  = ovf_q;
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (i_rd_sel == SEL_W'(i)) begin
        rd_mux = snap_arr[i];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        o_rd_data <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_multi_pulse_counter.sv
// Bench for multi_pulse_counter: three builds share stimulus,
// checked against an edge-event reference model and directed vectors.
module tb_multi_pulse_counter;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] pulse = 4'b0001;
  logic [3:0] clr = 4'b0;
  logic       en = 1'b1;
  logic [1:0] es = 2'b00;
  logic       snap = 1'b0;
  logic       rd_en = 1'b0;
  logic [1:0] rd_sel = 2'b0;

  logic [63:0] cnt0;
  logic [15:0] cnt1;
  logic [11:0] cnt2;
  logic [3:0]  ovf0, ovf1;
  logic [2:0]  ovf2;
  logic [15:0] rd0;
  logic [3:0]  rd1, rd2;
  logic        v0, v1, v2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_pulse_counter dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pulse(pulse), .i_en(en),
    .i_clr(clr), .i_edge_sel(es), .i_snap(snap), .i_rd_en(rd_en),
    .i_rd_sel(rd_sel), .o_cnt(cnt0), .o_ovf(ovf0),
    .o_rd_data(rd0), .o_rd_valid(v0)
  );

  multi_pulse_counter #(.CNT_W(4), .SAT_EN(1'b1)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_pulse(pulse), .i_en(en),
    .i_clr(clr), .i_edge_sel(es), .i_snap(snap), .i_rd_en(rd_en),
    .i_rd_sel(rd_sel), .o_cnt(cnt1), .o_ovf(ovf1),
    .o_rd_data(rd1), .o_rd_valid(v1)
  );

  multi_pulse_counter #(.CH_NUM(3), .CNT_W(4), .SAT_EN(1'b0)) dut_w (
    .i_clk(clk), .i_rst_n(rst_n), .i_pulse(pulse[2:0]), .i_en(en),
    .i_clr(clr[2:0]), .i_edge_sel(es), .i_snap(snap), .i_rd_en(rd_en),
    .i_rd_sel(rd_sel), .o_cnt(cnt2), .o_ovf(ovf2),
    .o_rd_data(rd2), .o_rd_valid(v2)
  );

  function automatic int chn(int c);
    return (c == 2) ? 3 : 4;
  endfunction

  function automatic int cmax(int c);
    return (c == 0) ? 65535 : 15;
  endfunction

  function automatic bit csat(int c);
    return c != 2;
  endfunction

  function automatic int got_cnt(int c, int n);
    case (c)
      0:       return int'(cnt0[n*16 +: 16]);
      1:       return int'(cnt1[n*4 +: 4]);
      default: return int'(cnt2[n*4 +: 4]);
    endcase
  endfunction

  function automatic int got_ovf(int c, int n);
    case (c)
      0:       return int'(ovf0[n]);
      1:       return int'(ovf1[n]);
      default: return int'(ovf2[n]);
    endcase
  endfunction

  function automatic int got_rd(int c);
    case (c)
      0:       return int'(rd0);
      1:       return int'(rd1);
      default: return int'(rd2);
    endcase
  endfunction

  function automatic int got_v(int c);
    case (c)
      0:       return int'(v0);
      1:       return int'(v1);
      default: return int'(v2);
    endcase
  endfunction

  task automatic chk(input string nm, input int c, input int n,
                     input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d ch%0d got %0h expected %0h",
               nm, c, n, got, exp);
    end
  endtask

  // Reference model: a count event at edge k is a selected transition
  // between the input levels sampled at edges k-S-1 and k-S.
  int m_cnt [3][4];
  int m_ovf [3][4];
  int m_snap[3][4];
  int m_rd  [3];
  int m_v   [3];
  int k = 0;
  logic [3:0] samp[$];

  task automatic model_reset();
    k = 0;
    samp.delete();
    for (int c = 0; c < 3; c++) begin
      m_rd[c] = 0;
      m_v[c]  = 0;
      for (int n = 0; n < 4; n++) begin
        m_cnt[c][n]  = 0;
        m_ovf[c][n]  = 0;
        m_snap[c][n] = 0;
      end
    end
  endtask

  task automatic model_step();
    logic [3:0] cur, prev, ev;
    k++;
    samp.push_back(pulse);
    cur  = (k > S)     ? samp[k-1-S] : 4'b0;
    prev = (k > S + 1) ? samp[k-2-S] : 4'b0;
    case (es)
      2'b00:   ev = cur & ~prev;
      2'b01:   ev = ~cur & prev;
      2'b10:   ev = cur ^ prev;
      default: ev = 4'b0;
    endcase
    for (int c = 0; c < 3; c++) begin
      if (rd_en) begin
        m_v[c]  = 1;
        m_rd[c] = (int'(rd_sel) < chn(c)) ? m_snap[c][rd_sel] : 0;
      end else begin
        m_v[c] = 0;
      end
      for (int n = 0; n < chn(c); n++) begin
        if (snap) m_snap[c][n] = m_cnt[c][n];
        if (clr[n]) begin
          m_cnt[c][n] = 0;
          m_ovf[c][n] = 0;
        end else if (ev[n] && en && k >= S + 2) begin
          if (m_cnt[c][n] == cmax(c)) begin
            m_ovf[c][n] = 1;
            if (!csat(c)) m_cnt[c][n] = 0;
          end else begin
            m_cnt[c][n]++;
          end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        for (int n = 0; n < chn(c); n++) begin
          chk("model_cnt", c, n, got_cnt(c, n), m_cnt[c][n]);
          chk("model_ovf", c, n, got_ovf(c, n), m_ovf[c][n]);
        end
        chk("model_rd_valid", c, 0, got_v(c), m_v[c]);
        chk("model_rd_data", c, 0, got_rd(c), m_rd[c]);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ch(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      pulse[ch] = 1'b0;
      cyc(3);
      pulse[ch] = 1'b1;
      cyc(3);
    end
    pulse[ch] = 1'b0;
    cyc(3);
  endtask

  typedef struct {
    int         ch;
    logic [1:0] es;
    int         np;
    logic       en;
    int         exp;
  } rec_t;

  rec_t tbl[5];

  initial begin
    tbl[0] = '{ch: 0, es: 2'b00, np: 5, en: 1'b1, exp: 5};
    tbl[1] = '{ch: 2, es: 2'b10, np: 3, en: 1'b1, exp: 6};
    tbl[2] = '{ch: 2, es: 2'b01, np: 2, en: 1'b1, exp: 8};
    tbl[3] = '{ch: 2, es: 2'b11, np: 2, en: 1'b1, exp: 8};
    tbl[4] = '{ch: 3, es: 2'b00, np: 4, en: 1'b0, exp: 0};

    #1;
    chk("rst_cnt", 0, 0, cnt0, 64'd0);
    chk("rst_ovf", 0, 0, {ovf0, ovf1, ovf2}, 64'd0);
    chk("rst_rd", 0, 0, {rd0, rd1, rd2, v0, v1, v2}, 64'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(6);
    chk("mask_high_line", 0, 0, got_cnt(0, 0), 0);

    foreach (tbl[i]) begin
      es = tbl[i].es;
      en = tbl[i].en;
      pulse_ch(tbl[i].ch, tbl[i].np);
      en = 1'b1;
      cyc(4);
      chk($sformatf("tbl%0d", i), 0, tbl[i].ch,
          got_cnt(0, tbl[i].ch), tbl[i].exp);
    end
    es = 2'b00;

    pulse[1] = 1'b1;
    @(posedge clk); #1;
    chk("lat_k0", 0, 1, got_cnt(0, 1), 0);
    @(posedge clk); #1;
    chk("lat_k1", 0, 1, got_cnt(0, 1), 0);
    @(posedge clk); #1;
    chk("lat_k2", 0, 1, got_cnt(0, 1), 1);
    @(negedge clk);
    cyc(2);
    pulse[1] = 1'b0;
    cyc(3);

    pulse_ch(1, 16);
    chk("cnt_17", 0, 1, got_cnt(0, 1), 17);
    chk("sat_cnt", 1, 1, got_cnt(1, 1), 15);
    chk("sat_ovf", 1, 1, got_ovf(1, 1), 1);
    chk("wrap_cnt", 2, 1, got_cnt(2, 1), 1);
    chk("wrap_ovf", 2, 1, got_ovf(2, 1), 1);
    clr = 4'b0010;
    cyc(1);
    clr = 4'b0;
    for (int c = 0; c < 3; c++) begin
      chk("clr_cnt", c, 1, got_cnt(c, 1), 0);
      chk("clr_ovf", c, 1, got_ovf(c, 1), 0);
    end

    pulse_ch(3, 7);
    chk("pre_clr3", 0, 3, got_cnt(0, 3), 7);
    pulse[3] = 1'b1;
    cyc(2);
    clr = 4'b1000;
    cyc(1);
    clr = 4'b0;
    chk("clr_edge_cnt", 0, 3, got_cnt(0, 3), 0);
    chk("clr_edge_ovf", 1, 3, got_ovf(1, 3), 0);
    cyc(4);
    chk("clr_edge_drop", 0, 3, got_cnt(0, 3), 0);
    pulse[3] = 1'b0;
    cyc(3);

    clr = 4'hf;
    cyc(1);
    clr = 4'h0;
    pulse_ch(0, 9);
    pulse_ch(1, 4);
    pulse_ch(3, 2);
    pulse[0] = 1'b1;
    cyc(2);
    snap = 1'b1;
    rd_en = 1'b1;
    rd_sel = 2'd0;
    cyc(1);
    snap = 1'b0;
    chk("rd_old_snap", 0, 0, rd0, 0);
    chk("rd_old_valid", 0, 0, v0, 1);
    chk("live_after_snap", 0, 0, got_cnt(0, 0), 10);
    cyc(1);
    chk("rd_sel0", 0, 0, rd0, 9);
    chk("rd_sel0_valid", 0, 0, v0, 1);
    rd_sel = 2'd1;
    cyc(1);
    chk("rd_sel1", 0, 1, rd0, 4);
    rd_sel = 2'd3;
    cyc(1);
    chk("rd_sel3", 0, 3, rd0, 2);
    chk("rd_sel3_oob", 2, 3, rd2, 0);
    chk("rd_sel3_oob_valid", 2, 3, v2, 1);
    rd_en = 1'b0;
    cyc(1);
    chk("rd_idle_valid", 0, 0, v0, 0);
    chk("rd_idle_hold", 0, 0, rd0, 2);
    pulse[0] = 1'b0;
    cyc(3);

    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(3) == 0) pulse[b] = ~pulse[b];
      end
      en = ($urandom_range(7) != 0);
      clr = 4'b0;
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(31) == 0) clr[b] = 1'b1;
      end
      if ($urandom_range(15) == 0) es = 2'($urandom_range(3));
      snap = ($urandom_range(7) == 0);
      rd_en = 1'($urandom_range(1));
      rd_sel = 2'($urandom_range(3));
      cyc(1);
    end
    pulse = 4'b0;
    clr = 4'b0;
    snap = 1'b0;
    rd_en = 1'b0;
    en = 1'b1;
    es = 2'b00;
    cyc(4);

    clr = 4'hf;
    cyc(1);
    clr = 4'h0;
    pulse_ch(0, 20);
    chk("pre_rst_cnt", 0, 0, got_cnt(0, 0), 20);
    chk("pre_rst_ovf", 1, 0, got_ovf(1, 0), 1);
    pulse[0] = 1'b1;
    cyc(3);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_cnt", 0, 0, {cnt0}, 64'd0);
    chk("async_rst_cnt_small", 1, 0, {cnt1, cnt2}, 64'd0);
    chk("async_rst_ovf", 0, 0, {ovf0, ovf1, ovf2}, 64'd0);
    chk("async_rst_rd", 0, 0, {rd0, rd1, rd2, v0, v1, v2}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(8);
    for (int c = 0; c < 3; c++) begin
      chk("remask", c, 0, got_cnt(c, 0), 0);
    end
    pulse_ch(0, 1);
    chk("after_remask", 0, 0, got_cnt(0, 0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
